// File: rtl/eth_frame_loop_mem_arbiter_pkg.sv
// Shared types and constants for the eth_frame_loop script-memory arbiter.
package eth_frame_loop_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    localparam int TIMEOUT_COUNT_W = 16;

endpackage

// File: rtl/eth_frame_loop_rr_select.sv
// Combinational round-robin selector: first requester at or after ptr, searched cyclically.
module eth_frame_loop_rr_select #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any_req
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             offs;
    int             idx;

    // Rotating the doubled vector puts requester ptr at bit 0, so the lowest set bit is the winner.
    always_comb begin
        dbl  = {req, req} >> ptr;
        rot  = dbl[N-1:0];
        offs = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) offs = j;
        end
        idx = int'(ptr) + offs;
        if (idx >= N) idx = idx - N;
        grant = IDX_W'(idx);
    end

    assign any_req = |req;

endmodule

// File: rtl/eth_frame_loop_mem_arbiter.sv
// Round-robin arbiter sharing eth_frame_loop's single script-memory port, with an
// access watchdog that terminates accesses the memory never acknowledges.
module eth_frame_loop_mem_arbiter
    import eth_frame_loop_mem_arbiter_pkg::*;
#(
    parameter int C_NUM_REQ    = 2,
    parameter int C_AXI_WIDTH  = 32,
    parameter int C_ADDR_WIDTH = 15,
    parameter int C_TIMEOUT    = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [C_NUM_REQ-1:0]              s_req,
    input  logic [C_NUM_REQ*C_ADDR_WIDTH-1:0] s_addr,
    input  logic [C_NUM_REQ-1:0]              s_wenable,
    input  logic [C_NUM_REQ*C_AXI_WIDTH-1:0]  s_wdata,
    output logic [C_AXI_WIDTH-1:0]            s_rdata,
    output logic [C_NUM_REQ-1:0]              s_ack,
    output logic [C_NUM_REQ-1:0]              s_err,
    output logic                              m_req,
    output logic [C_ADDR_WIDTH-1:0]           m_addr,
    output logic                              m_wenable,
    output logic [C_AXI_WIDTH-1:0]            m_wdata,
    input  logic [C_AXI_WIDTH-1:0]            m_rdata,
    input  logic                              m_ack,
    output logic                              busy,
    output logic [TIMEOUT_COUNT_W-1:0]        timeout_count
);

    localparam int IDX_W = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
    localparam logic [15:0] TIMER_LAST = 16'(C_TIMEOUT - 1);

    state_t                   state;
    logic [IDX_W-1:0]         ptr;
    logic [IDX_W-1:0]         grant_q;
    logic [15:0]              timer;

    logic [IDX_W-1:0]         sel;
    logic                     any_req;
    logic [IDX_W-1:0]         ptr_next;
    logic [C_NUM_REQ-1:0]     grant_oh;
    logic [C_ADDR_WIDTH-1:0]  sel_addr;
    logic [C_AXI_WIDTH-1:0]   sel_wdata;
    logic                     sel_we;

    eth_frame_loop_rr_select #(
        .N     (C_NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req     (s_req),
        .ptr     (ptr),
        .grant   (sel),
        .any_req (any_req)
    );

    always_comb begin
        ptr_next  = (int'(sel) == C_NUM_REQ - 1) ? '0 : sel + 1'b1;
        sel_addr  = s_addr[sel*C_ADDR_WIDTH +: C_ADDR_WIDTH];
        sel_wdata = s_wdata[sel*C_AXI_WIDTH +: C_AXI_WIDTH];
        sel_we    = s_wenable[sel];
        grant_oh  = '0;
        grant_oh[grant_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            grant_q       <= '0;
            timer         <= '0;
            s_rdata       <= '0;
            s_ack         <= '0;
            s_err         <= '0;
            m_req         <= 1'b0;
            m_addr        <= '0;
            m_wenable     <= 1'b0;
            m_wdata       <= '0;
            busy          <= 1'b0;
            timeout_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q   <= sel;
                        ptr       <= ptr_next;
                        m_addr    <= sel_addr;
                        m_wenable <= sel_we;
                        m_wdata   <= sel_wdata;
                        m_req     <= 1'b1;
                        timer     <= '0;
                        busy      <= 1'b1;
                        state     <= ST_BUSY;
                    end
                end
                // An ack arriving on the expiry cycle takes priority over the watchdog.
                ST_BUSY: begin
                    if (m_ack) begin
                        if (!m_wenable) s_rdata <= m_rdata;
                        s_ack <= grant_oh;
                        m_req <= 1'b0;
                        state <= ST_DONE;
                    end else if (timer == TIMER_LAST) begin
                        s_ack   <= grant_oh;
                        s_err   <= grant_oh;
                        s_rdata <= '0;
                        m_req   <= 1'b0;
                        if (timeout_count != '1) timeout_count <= timeout_count + 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                // One dead cycle keeps m_req low between accesses and lets requesters update s_req.
                ST_DONE: begin
                    s_ack <= '0;
                    s_err <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_loop_mem_arbiter.sv
// Self-checking bench for eth_frame_loop_mem_arbiter with a round-robin reference model.
module tb_eth_frame_loop_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    s_req;
    logic [N*AW-1:0] s_addr;
    logic [N-1:0]    s_wenable;
    logic [N*DW-1:0] s_wdata;
    logic [DW-1:0]   s_rdata;
    logic [N-1:0]    s_ack;
    logic [N-1:0]    s_err;
    logic            m_req;
    logic [AW-1:0]   m_addr;
    logic            m_wenable;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            m_ack;
    logic            busy;
    logic [15:0]     timeout_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            mdl_ptr   = 0;
    logic [DW-1:0] mdl_rdata = '0;
    int            mdl_tc    = 0;

    always #5 clk = ~clk;

    eth_frame_loop_mem_arbiter #(
        .C_NUM_REQ    (N),
        .C_AXI_WIDTH  (DW),
        .C_ADDR_WIDTH (AW),
        .C_TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_req         (s_req),
        .s_addr        (s_addr),
        .s_wenable     (s_wenable),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata),
        .s_ack         (s_ack),
        .s_err         (s_err),
        .m_req         (m_req),
        .m_addr        (m_addr),
        .m_wenable     (m_wenable),
        .m_wdata       (m_wdata),
        .m_rdata       (m_rdata),
        .m_ack         (m_ack),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    function automatic int rr_pick(input logic [N-1:0] mask, input int p);
        for (int k = 0; k < N; k++) begin
            if (mask[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; s_req = '0; s_addr = '0; s_wenable = '0; s_wdata = '0;
        m_ack = 1'b0; m_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mdl_ptr = 0; mdl_rdata = '0; mdl_tc = 0;
    endtask

    // Memory responder: waits for m_req, acks after lat cycles (if give_ack), returns observations.
    task automatic serve(input int lat, input bit give_ack, input bit perturb, input logic [DW-1:0] rd,
                         output int wait_c, output int ack_c, output int gnt,
                         output logic [AW-1:0] a, output logic we, output logic [DW-1:0] wd,
                         output bit stable, output logic [N-1:0] err);
        wait_c = 0; ack_c = -1; gnt = -1; stable = 1'b1; err = '0;
        while (!m_req && wait_c < 20) begin
            @(posedge clk); #1; wait_c++;
        end
        a = m_addr; we = m_wenable; wd = m_wdata;
        if (m_req) begin
            for (int c = 0; c < 40; c++) begin
                if (perturb && c == 1) begin
                    s_wdata = {$urandom, $urandom}; s_addr = 30'($urandom); s_wenable = ~s_wenable;
                end
                m_ack   = give_ack && (c == lat);
                m_rdata = (c == lat) ? rd : $urandom;
                @(posedge clk); #1;
                m_ack = 1'b0;
                if (m_addr !== a || m_wenable !== we || m_wdata !== wd) stable = 1'b0;
                if (s_ack != '0) begin
                    ack_c = c + 1; gnt = s_ack[1] ? 1 : 0; err = s_err;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({m_req, busy, s_ack, s_err} !== 6'b0) begin n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000", {m_req, busy, s_ack, s_err}); end
        n_checks++; if (s_rdata !== '0 || m_addr !== '0 || m_wdata !== '0 || m_wenable !== 1'b0) begin n_fail++;
            $display("FAIL reset_data: rdata %h addr %h wdata %h we %b required 0", s_rdata, m_addr, m_wdata, m_wenable); end
        n_checks++; if (timeout_count !== 16'd0) begin n_fail++;
            $display("FAIL reset_tc: got %0d required 0", timeout_count); end
    endtask

    task automatic test_single_read();
        int wc, ac, g; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; bit st; logic [N-1:0] err;
        s_wenable = '0; s_addr[0 +: AW] = 15'h0123; s_req = 2'b01;
        serve(3, 1'b1, 1'b0, 32'hDEADBEEF, wc, ac, g, a, we, wd, st, err);
        n_checks++; if (wc !== 1) begin n_fail++; $display("FAIL read_req_latency: got %0d required 1", wc); end
        n_checks++; if (ac !== 4) begin n_fail++; $display("FAIL read_ack_latency: got %0d required 4", ac); end
        n_checks++; if (g !== 0 || a !== 15'h0123 || we !== 1'b0) begin n_fail++;
            $display("FAIL read_grant: grant %0d addr %h we %b required 0 0123 0", g, a, we); end
        n_checks++; if (s_rdata !== 32'hDEADBEEF || err !== 2'b00) begin n_fail++;
            $display("FAIL read_data: rdata %h err %b required deadbeef 00", s_rdata, err); end
        n_checks++; if (m_req !== 1'b0 || busy !== 1'b1) begin n_fail++;
            $display("FAIL read_done_state: m_req %b busy %b required 0 1", m_req, busy); end
        mdl_rdata = 32'hDEADBEEF; mdl_ptr = 1;
        s_req = '0; @(posedge clk); #1;
        n_checks++; if (s_ack !== 2'b00 || busy !== 1'b0) begin n_fail++;
            $display("FAIL read_ack_pulse: s_ack %b busy %b required 00 0", s_ack, busy); end
    endtask

    task automatic test_write_stability();
        int wc, ac, g, eg; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; bit st; logic [N-1:0] err;
        s_wenable = 2'b10; s_addr[AW +: AW] = 15'h7FFF; s_wdata[DW +: DW] = 32'hA5A5A5A5; s_req = 2'b10;
        eg = rr_pick(2'b10, mdl_ptr);
        serve(4, 1'b1, 1'b1, 32'h0BADF00D, wc, ac, g, a, we, wd, st, err);
        n_checks++; if (g !== eg || ac !== 5) begin n_fail++;
            $display("FAIL write_grant: grant %0d ack_cyc %0d required %0d 5", g, ac, eg); end
        n_checks++; if (a !== 15'h7FFF || we !== 1'b1 || wd !== 32'hA5A5A5A5) begin n_fail++;
            $display("FAIL write_latch: addr %h we %b wdata %h required 7fff 1 a5a5a5a5", a, we, wd); end
        n_checks++; if (st !== 1'b1 || m_wdata !== 32'hA5A5A5A5) begin n_fail++;
            $display("FAIL write_stable: stable %b m_wdata %h required 1 a5a5a5a5", st, m_wdata); end
        n_checks++; if (s_rdata !== mdl_rdata) begin n_fail++;
            $display("FAIL write_rdata_kept: got %h required %h", s_rdata, mdl_rdata); end
        mdl_ptr = (eg + 1) % N;
        s_req = '0; s_wenable = '0; @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int wc, ac, g, eg; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; bit st; logic [N-1:0] err;
        bit quiet;
        s_wenable = '0; s_addr = {15'h0AA, 15'h055}; s_req = 2'b01;
        eg = rr_pick(2'b01, mdl_ptr);
        serve(0, 1'b0, 1'b0, '0, wc, ac, g, a, we, wd, st, err);
        mdl_tc++; mdl_rdata = '0; mdl_ptr = (eg + 1) % N;
        n_checks++; if (ac !== TO || g !== eg) begin n_fail++;
            $display("FAIL timeout_latency: ack_cyc %0d grant %0d required %0d %0d", ac, g, TO, eg); end
        n_checks++; if (err !== 2'b01 || s_rdata !== '0) begin n_fail++;
            $display("FAIL timeout_err: err %b rdata %h required 01 0", err, s_rdata); end
        n_checks++; if (timeout_count !== 16'(mdl_tc)) begin n_fail++;
            $display("FAIL timeout_count: got %0d required %0d", timeout_count, mdl_tc); end
        s_req = '0;
        @(posedge clk); #1;
        n_checks++; if (s_err !== 2'b00 || s_ack !== 2'b00) begin n_fail++;
            $display("FAIL timeout_pulse: s_ack %b s_err %b required 00 00", s_ack, s_err); end
        @(posedge clk); #1;
        m_ack = 1'b1; m_rdata = 32'h12345678;
        @(posedge clk); #1;
        m_ack = 1'b0;
        quiet = 1'b1;
        repeat (3) begin
            if (s_rdata !== '0 || s_ack !== '0 || busy !== 1'b0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++; if (quiet !== 1'b1) begin n_fail++;
            $display("FAIL late_ack_ignored: rdata %h s_ack %b busy %b required 0 00 0", s_rdata, s_ack, busy); end
    endtask

    task automatic test_ack_tie();
        int wc, ac, g, eg; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; bit st; logic [N-1:0] err;
        logic [DW-1:0] rd;
        rd = $urandom; s_wenable = '0; s_req = 2'b10;
        eg = rr_pick(2'b10, mdl_ptr);
        serve(TO - 1, 1'b1, 1'b0, rd, wc, ac, g, a, we, wd, st, err);
        mdl_rdata = rd; mdl_ptr = (eg + 1) % N;
        n_checks++; if (ac !== TO || err !== 2'b00) begin n_fail++;
            $display("FAIL tie_no_err: ack_cyc %0d err %b required %0d 00", ac, err, TO); end
        n_checks++; if (s_rdata !== rd || timeout_count !== 16'(mdl_tc)) begin n_fail++;
            $display("FAIL tie_data: rdata %h tc %0d required %h %0d", s_rdata, timeout_count, rd, mdl_tc); end
        s_req = '0; @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        int wc, ac, g, eg; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; bit st; logic [N-1:0] err;
        do_reset();
        s_wenable = '0; s_addr = {15'h0B00, 15'h0A00}; s_req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            eg = rr_pick(2'b11, mdl_ptr);
            serve(1, 1'b1, 1'b0, 32'(i), wc, ac, g, a, we, wd, st, err);
            mdl_ptr = (eg + 1) % N; mdl_rdata = 32'(i);
            n_checks++; if (g !== eg || a !== s_addr[eg*AW +: AW]) begin n_fail++;
                $display("FAIL fair_order[%0d]: grant %0d addr %h required %0d", i, g, a, eg); end
            n_checks++; if (m_req !== 1'b0 || ac !== 2 || (i > 0 && wc < 1)) begin n_fail++;
                $display("FAIL fair_gap[%0d]: m_req %b ack_cyc %0d gap %0d", i, m_req, ac, wc); end
        end
        s_req = '0; @(posedge clk); #1;
    endtask

    task automatic test_random();
        int wc, ac, g, eg, lat; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; bit st; logic [N-1:0] err;
        logic [N-1:0] mask; logic [DW-1:0] rd;
        for (int i = 0; i < 24; i++) begin
            mask = 2'($urandom_range(1, 3)); lat = $urandom_range(0, 5); rd = $urandom;
            s_addr = 30'($urandom); s_wdata = {$urandom, $urandom}; s_wenable = 2'($urandom);
            eg = rr_pick(mask, mdl_ptr);
            s_req = mask;
            serve(lat, 1'b1, 1'b0, rd, wc, ac, g, a, we, wd, st, err);
            if (!s_wenable[eg]) mdl_rdata = rd;
            mdl_ptr = (eg + 1) % N;
            n_checks++;
            if (g !== eg || ac !== lat + 1 || a !== s_addr[eg*AW +: AW] || we !== s_wenable[eg] ||
                wd !== s_wdata[eg*DW +: DW] || err !== '0 || s_rdata !== mdl_rdata) begin
                n_fail++;
                $display("FAIL random[%0d]: grant %0d/%0d ack_cyc %0d/%0d addr %h we %b rdata %h/%h err %b",
                         i, g, eg, ac, lat + 1, a, we, s_rdata, mdl_rdata, err);
            end
            s_req = '0; @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_access();
        int wc, ac, g; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; bit st; logic [N-1:0] err;
        bit no_ack;
        s_wenable = '0; s_req = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: m_req %b required 1", m_req); end
        rst_n = 1'b0; s_req = '0;
        #1;
        n_checks++; if (m_req !== 1'b0 || busy !== 1'b0 || timeout_count !== 16'd0) begin n_fail++;
            $display("FAIL rst_mid_async: m_req %b busy %b tc %0d required 0 0 0", m_req, busy, timeout_count); end
        no_ack = 1'b1;
        repeat (2) begin @(posedge clk); #1; if (s_ack !== '0) no_ack = 1'b0; end
        rst_n = 1'b1; mdl_ptr = 0; mdl_rdata = '0; mdl_tc = 0;
        repeat (2) begin @(posedge clk); #1; if (s_ack !== '0 || m_req !== 1'b0) no_ack = 1'b0; end
        n_checks++; if (no_ack !== 1'b1) begin n_fail++; $display("FAIL rst_mid_no_ack: s_ack %b m_req %b", s_ack, m_req); end
        s_req = 2'b11;
        serve(2, 1'b1, 1'b0, 32'hCAFE0001, wc, ac, g, a, we, wd, st, err);
        n_checks++; if (g !== rr_pick(2'b11, mdl_ptr) || ac !== 3) begin n_fail++;
            $display("FAIL rst_mid_ptr: grant %0d ack_cyc %0d required 0 3", g, ac); end
        s_req = '0; @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_stability();
        test_timeout();
        test_ack_tie();
        test_fairness();
        test_random();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
